// File: rtl/dm14_tdm.sv
// Four-lane TDM demultiplexer: steers a serial beat stream into lanes a..d by slot,
// publishing each complete frame at once with a one-cycle frame_valid strobe.
module dm14_tdm #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         sof,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic         s1,
    output logic         s0,
    output logic         frame_valid,
    output logic         err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state;
    logic [1:0]   slot;
    logic [W-1:0] sh0, sh1, sh2;

    assign {s1, s0} = slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            slot        <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            a           <= '0;
            b           <= '0;
            c           <= '0;
            d           <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (sof) begin
                            sh0   <= in_data;
                            slot  <= 2'd1;
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (sof) begin
                            // sof anywhere but slot 0 abandons the partial frame
                            if (slot != 2'd0)
                                err <= 1'b1;
                            sh0  <= in_data;
                            slot <= 2'd1;
                        end else begin
                            case (slot)
                                2'd0: begin
                                    err   <= 1'b1;
                                    slot  <= 2'd0;
                                    state <= IDLE;
                                end
                                2'd1: begin
                                    sh1  <= in_data;
                                    slot <= 2'd2;
                                end
                                2'd2: begin
                                    sh2  <= in_data;
                                    slot <= 2'd3;
                                end
                                default: begin
                                    // lane d bypasses the shadows so all four lanes land together
                                    a           <= sh0;
                                    b           <= sh1;
                                    c           <= sh2;
                                    d           <= in_data;
                                    frame_valid <= 1'b1;
                                    slot        <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state <= IDLE;
                        slot  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dm14_tdm.sv
// Scoreboard bench for dm14_tdm: stimulus queues expected frames, a monitor
// pops one per frame_valid pulse; control outputs are checked directly.
module tb_dm14_tdm;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         sof;
    logic [W-1:0] a, b, c, d;
    logic         s1, s0, frame_valid, err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    int last_pulse_cyc = 0;
    int first_pulse_cyc = 0;
    int pulse_mark;
    logic [15:0] expq[$];
    logic [15:0] last_frame = '0;

    dm14_tdm #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .sof(sof),
        .a(a), .b(b), .c(c), .d(d), .s1(s1), .s0(s0),
        .frame_valid(frame_valid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next queued frame; lanes stay frozen otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last_frame = '0;
        end else if (frame_valid) begin
            pulses++;
            last_pulse_cyc = cyc;
            if (expq.size() == 0) begin
                chk("unexpected_frame", {a, b, c, d}, 16'hxxxx);
            end else begin
                chk("frame_lanes", {a, b, c, d}, expq.pop_front());
            end
            last_frame = {a, b, c, d};
        end else begin
            chk("lanes_hold", {a, b, c, d}, last_frame);
        end
    end

    task automatic send(input logic [W-1:0] dat, input logic s);
        in_valid = 1'b1;
        in_data  = dat;
        sof      = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        sof      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        sof = 1'b0;
        repeat (2) begin
            in_valid = 1'($urandom);
            sof      = 1'($urandom);
            in_data  = W'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        sof = 1'b0;
        chk("reset_lanes", {a, b, c, d}, 16'h0000);
        chk("reset_slot", {14'd0, s1, s0}, 16'd0);
        chk("reset_fv", {15'd0, frame_valid}, 16'd0);
        chk("reset_err", {15'd0, err}, 16'd0);
        idle(1);

        // Gapless back-to-back frames
        expq.push_back(16'h1234);
        send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        chk("gapless_fv_high", {15'd0, frame_valid}, 16'd1);
        chk("gapless_lanes", {a, b, c, d}, 16'h1234);
        first_pulse_cyc = cyc;
        expq.push_back(16'h5678);
        send(4'h5, 1'b1);
        chk("gapless_fv_low", {15'd0, frame_valid}, 16'd0);
        send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
        chk("gapless_fv2", {15'd0, frame_valid}, 16'd1);
        chk("gapless_spacing", 16'(cyc - first_pulse_cyc), 16'd4);
        chk("gapless_err", {15'd0, err}, 16'd0);
        idle(1);

        // Frame with idle gaps between beats
        expq.push_back(16'h1234);
        send(4'h1, 1'b1); idle(2);
        chk("gap_slot1", {14'd0, s1, s0}, 16'd1);
        send(4'h2, 1'b0); idle(2);
        chk("gap_slot2", {14'd0, s1, s0}, 16'd2);
        send(4'h3, 1'b0); idle(2);
        chk("gap_slot3", {14'd0, s1, s0}, 16'd3);
        send(4'h4, 1'b0);
        chk("gap_lanes", {a, b, c, d}, 16'h1234);
        idle(2);
        chk("gap_slot0", {14'd0, s1, s0}, 16'd0);

        // Beats before the first sof are dropped silently
        do_reset();
        send(4'hF, 1'b0); send(4'hF, 1'b0);
        chk("presync_slot", {14'd0, s1, s0}, 16'd0);
        chk("presync_err", {15'd0, err}, 16'd0);
        expq.push_back(16'h9ABC);
        send(4'h9, 1'b1); send(4'hA, 1'b0); send(4'hB, 1'b0); send(4'hC, 1'b0);
        chk("presync_lanes", {a, b, c, d}, 16'h9ABC);
        idle(1);
        chk("presync_err2", {15'd0, err}, 16'd0);

        // Early sof restarts the frame and flags err
        pulse_mark = pulses;
        expq.push_back(16'h5678);
        send(4'h1, 1'b1); send(4'h2, 1'b0);
        chk("early_err_before", {15'd0, err}, 16'd0);
        send(4'h5, 1'b1);
        chk("early_err", {15'd0, err}, 16'd1);
        chk("early_slot", {14'd0, s1, s0}, 16'd1);
        send(4'h6, 1'b0); send(4'h7, 1'b0); send(4'h8, 1'b0);
        chk("early_lanes", {a, b, c, d}, 16'h5678);
        idle(2);
        chk("early_one_pulse", 16'(pulses - pulse_mark), 16'd1);

        // Early sof on slot 3 emits no frame
        do_reset();
        pulse_mark = pulses;
        send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b1);
        chk("slot3_sof_fv", {15'd0, frame_valid}, 16'd0);
        chk("slot3_sof_err", {15'd0, err}, 16'd1);
        idle(1);
        chk("slot3_sof_nopulse", 16'(pulses - pulse_mark), 16'd0);

        // Missing sof after a full frame
        do_reset();
        chk("rst_clears_err", {15'd0, err}, 16'd0);
        expq.push_back(16'h1234);
        send(4'h1, 1'b1); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
        send(4'h3, 1'b0);
        chk("missing_err", {15'd0, err}, 16'd1);
        chk("missing_slot", {14'd0, s1, s0}, 16'd0);
        chk("missing_lanes", {a, b, c, d}, 16'h1234);
        send(4'h7, 1'b0);
        chk("idle_drop_slot", {14'd0, s1, s0}, 16'd0);
        idle(1);

        // Reset in the middle of a frame
        send(4'h1, 1'b1); send(4'h2, 1'b0);
        do_reset();
        chk("midrst_lanes", {a, b, c, d}, 16'h0000);
        chk("midrst_slot", {14'd0, s1, s0}, 16'd0);
        chk("midrst_err", {15'd0, err}, 16'd0);
        chk("midrst_fv", {15'd0, frame_valid}, 16'd0);
        expq.push_back(16'hDEF1);
        send(4'hD, 1'b1); send(4'hE, 1'b0); send(4'hF, 1'b0); send(4'h1, 1'b0);
        chk("postrst_lanes", {a, b, c, d}, 16'hDEF1);
        idle(2);
        chk("postrst_err", {15'd0, err}, 16'd0);

        chk("queue_drained", 16'(expq.size()), 16'd0);
        chk("pulse_total", 16'(pulses), 16'd7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
